// File: rtl/uart_cmd_rx.sv
// UART command receiver: 8N1 deserialiser with ASCII key decode into one-cycle move pulses.
// Define UART_CMD_RX_PARITY_EN for 8E1 frames with an even-parity check and a parity_err pulse.
module uart_cmd_rx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
`ifdef UART_CMD_RX_PARITY_EN
   output logic       parity_err,
`endif
   output logic       cmd_up,
   output logic       cmd_down,
   output logic       cmd_left,
   output logic       cmd_right,
   output logic       cmd_center,
   output logic [2:0] dbg_state
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_BIT - 1);
   localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_DATA    = 3'd2,
      S_STOP    = 3'd3,
      S_RECOVER = 3'd4
`ifdef UART_CMD_RX_PARITY_EN
      , S_PARITY = 3'd5
`endif
   } state_t;

   // Handshake: every output is a valid-only strobe with no ready; a consumer
   // must capture rx_data in the single cycle rx_valid is high.
   state_t          state_q, state_d;
   logic            sync1_q, rxs_q;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      rx_data_q, rx_data_d;
   logic            rx_valid_q, rx_valid_d;
   logic            frame_err_q, frame_err_d;
   logic [4:0]      cmd_q, cmd_d;
   logic            cnt_zero;
`ifdef UART_CMD_RX_PARITY_EN
   logic            par_bad_q, par_bad_d;
   logic            parity_err_q, parity_err_d;
`endif

   // Returns {center, right, left, down, up}; at most one bit is ever set.
   function automatic logic [4:0] decode_cmd(input logic [7:0] b);
      case (b)
         8'h77, 8'h57: return 5'b00001;
         8'h73, 8'h53: return 5'b00010;
         8'h61, 8'h41: return 5'b00100;
         8'h64, 8'h44: return 5'b01000;
         8'h20:        return 5'b10000;
         default:      return 5'b00000;
      endcase
   endfunction

   assign cnt_zero = (cnt_q == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         rxs_q   <= 1'b1;
      end else begin
         sync1_q <= rxd;
         rxs_q   <= sync1_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      cmd_d       = 5'b00000;
`ifdef UART_CMD_RX_PARITY_EN
      par_bad_d    = par_bad_q;
      parity_err_d = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (!rxs_q) begin
               state_d = S_START;
               cnt_d   = HALF_LOAD;
            end
         end
         S_START: begin
            if (!cnt_zero) begin
               cnt_d = cnt_q - CNT_ONE;
            end else if (!rxs_q) begin
               state_d = S_DATA;
               cnt_d   = BIT_LOAD;
               idx_d   = 3'd0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_DATA: begin
            if (!cnt_zero) begin
               cnt_d = cnt_q - CNT_ONE;
            end else begin
               shift_d[idx_q] = rxs_q;
               cnt_d          = BIT_LOAD;
               idx_d          = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
`ifdef UART_CMD_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_CMD_RX_PARITY_EN
         S_PARITY: begin
            if (!cnt_zero) begin
               cnt_d = cnt_q - CNT_ONE;
            end else begin
               // Even parity: data bits plus parity bit must have an even popcount.
               par_bad_d = ^{shift_q, rxs_q};
               cnt_d     = BIT_LOAD;
               state_d   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (!cnt_zero) begin
               cnt_d = cnt_q - CNT_ONE;
            end else if (rxs_q) begin
               state_d = S_IDLE;
`ifdef UART_CMD_RX_PARITY_EN
               if (par_bad_q) begin
                  parity_err_d = 1'b1;
               end else begin
                  rx_data_d  = shift_q;
                  rx_valid_d = 1'b1;
                  cmd_d      = decode_cmd(shift_q);
               end
`else
               rx_data_d  = shift_q;
               rx_valid_d = 1'b1;
               cmd_d      = decode_cmd(shift_q);
`endif
            end else begin
               frame_err_d = 1'b1;
               state_d     = S_RECOVER;
            end
         end
         S_RECOVER: begin
            // A held-low break must not retrigger START until the line idles.
            if (rxs_q) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         idx_q       <= 3'd0;
         shift_q     <= 8'h00;
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         cmd_q       <= 5'b00000;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         cmd_q       <= cmd_d;
      end
   end

`ifdef UART_CMD_RX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         par_bad_q    <= par_bad_d;
         parity_err_q <= parity_err_d;
      end
   end

   assign parity_err = parity_err_q;
`endif

   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign frame_err  = frame_err_q;
   assign cmd_up     = cmd_q[0];
   assign cmd_down   = cmd_q[1];
   assign cmd_left   = cmd_q[2];
   assign cmd_right  = cmd_q[3];
   assign cmd_center = cmd_q[4];
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Randomised self-checking bench for uart_cmd_rx, checked against a byte-level reference model.
// Honours UART_CMD_RX_PARITY_EN to exercise the 8E1 build.
module tb_uart_cmd_rx;

   localparam int BIT = 16;
   localparam logic [2:0] IDLE_CODE = 3'd0;
`ifdef UART_CMD_RX_PARITY_EN
   localparam int FRAME_BITS = 10;
`else
   localparam int FRAME_BITS = 9;
`endif
   // Start edge to observed rx_valid: about (FRAME_BITS + 0.5) bit periods plus sync/register delay.
   localparam int LAT_NOM = FRAME_BITS * BIT + BIT / 2 + 3;

   logic       clk;
   logic       rst_n;
   logic       rxd;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       parity_err;
   logic       cmd_up, cmd_down, cmd_left, cmd_right, cmd_center;
   logic [2:0] dbg_state;
   logic [4:0] cmd_vec;

   assign cmd_vec = {cmd_center, cmd_right, cmd_left, cmd_down, cmd_up};

   uart_cmd_rx #(.CLKS_PER_BIT(BIT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rxd        (rxd),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .frame_err  (frame_err),
`ifdef UART_CMD_RX_PARITY_EN
      .parity_err (parity_err),
`endif
      .cmd_up     (cmd_up),
      .cmd_down   (cmd_down),
      .cmd_left   (cmd_left),
      .cmd_right  (cmd_right),
      .cmd_center (cmd_center),
      .dbg_state  (dbg_state)
   );

`ifndef UART_CMD_RX_PARITY_EN
   assign parity_err = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- checking ----------------
   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] exp_q[$];
   logic [7:0] exp_last = 8'h00;
   int         exp_ferr = 0;
   int         exp_perr = 0;
   int         ferr_seen = 0;
   int         perr_seen = 0;
   int         start_cyc = 0;

   // Key map expressed on characters: fold upper-case letters to lower case first.
   function automatic logic [4:0] model_cmd(input logic [7:0] b);
      int c;
      c = b;
      if (c >= 65 && c <= 90) c = c + 32;
      if (c == 119) return 5'b00001;  // w
      if (c == 115) return 5'b00010;  // s
      if (c == 97)  return 5'b00100;  // a
      if (c == 100) return 5'b01000;  // d
      if (c == 32)  return 5'b10000;  // space
      return 5'b00000;
   endfunction

   // ---------------- scoreboard / monitor ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_valid) begin
            logic [7:0] e;
            int lat;
            check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               lat = cyc - start_cyc;
               check("rx_data", {24'd0, rx_data}, {24'd0, e});
               check("cmd_vec", {27'd0, cmd_vec}, {27'd0, model_cmd(e)});
               check("latency_window", 32'(lat >= LAT_NOM - 2 && lat <= LAT_NOM + 2), 32'd1);
            end
         end else if (cmd_vec != 5'b00000) begin
            check("cmd_without_valid", {27'd0, cmd_vec}, 32'd0);
         end
         if (frame_err) ferr_seen++;
         if (parity_err) perr_seen++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_bit(input logic b);
      rxd = b;
      repeat (BIT) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par_b, input logic stop_b);
      start_cyc = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_CMD_RX_PARITY_EN
      drive_bit(par_b);
`else
      if (par_b) begin end
`endif
      drive_bit(stop_b);
   endtask

   task automatic send_byte(input logic [7:0] d);
      exp_q.push_back(d);
      exp_last = d;
      send_frame(d, ^d, 1'b1);
   endtask

   task automatic idle_bits(input int n);
      rxd = 1'b1;
      repeat (n * BIT) @(negedge clk);
   endtask

   task automatic settle_and_check(input string tag);
      idle_bits(2);
      check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_rx_data"}, {24'd0, rx_data}, {24'd0, exp_last});
      check({tag, "_frame_errs"}, 32'(ferr_seen), 32'(exp_ferr));
      check({tag, "_parity_errs"}, 32'(perr_seen), 32'(exp_perr));
   endtask

   // ---------------- stimulus ----------------
   logic [7:0] keys [0:8];

   initial begin
      keys = '{8'h77, 8'h57, 8'h61, 8'h53, 8'h64, 8'h44, 8'h20, 8'h73, 8'h41};
      rxd   = 1'b1;
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_rx_data", {24'd0, rx_data}, 32'd0);
      check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("rst_frame_err", {31'd0, frame_err}, 32'd0);
      check("rst_cmd", {27'd0, cmd_vec}, 32'd0);
      check("rst_state", {29'd0, dbg_state}, {29'd0, IDLE_CODE});
      rst_n = 1'b1;
      idle_bits(2);

      // 'w' with a good stop bit
      send_byte(8'h77);
      settle_and_check("w_byte");

      // 'A' then space back-to-back
      send_byte(8'h41);
      send_byte(8'h20);
      settle_and_check("back_to_back");

      // bad stop then a long break: exactly one frame error, rx_data kept
      send_frame(8'h5A, ^8'h5A, 1'b0);
      exp_ferr++;
      rxd = 1'b0;
      repeat (40 * BIT) @(negedge clk);
      idle_bits(2);
      check("break_rx_data", {24'd0, rx_data}, 32'h20);
      send_byte(8'h73);
      settle_and_check("break_then_s");

      // 5-cycle glitch is rejected at the start mid-sample
      rxd = 1'b0;
      repeat (5) @(negedge clk);
      rxd = 1'b1;
      repeat (BIT) @(negedge clk);
      check("glitch_state", {29'd0, dbg_state}, {29'd0, IDLE_CODE});
      settle_and_check("glitch");

      // reset during data bit 4 of 0x64, then a clean 0x64
      rxd = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 4; i++) drive_bit(8'h64 >> i);
      rxd = 1'b0;
      repeat (BIT / 2) @(negedge clk);
      rst_n = 1'b0;
      rxd   = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
      check("midrst_state", {29'd0, dbg_state}, {29'd0, IDLE_CODE});
      rst_n = 1'b1;
      exp_last = 8'h00;
      idle_bits(3);
      send_byte(8'h64);
      settle_and_check("after_reset");

`ifdef UART_CMD_RX_PARITY_EN
      // 0x77 has popcount 6: parity 1 is wrong, parity 0 is right
      send_frame(8'h77, 1'b1, 1'b1);
      exp_perr++;
      settle_and_check("parity_bad");
      send_byte(8'h77);
      settle_and_check("parity_good");
`endif

      // randomised traffic, keys mixed with arbitrary bytes and gaps
      for (int n = 0; n < 16; n++) begin
         logic [7:0] d;
         if ($urandom_range(0, 1) == 1) d = keys[$urandom_range(0, 8)];
         else d = 8'($urandom_range(0, 255));
         send_byte(d);
         idle_bits($urandom_range(0, 3));
      end
      settle_and_check("random");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
